// File: rtl/line_buffer_taps.sv
// line_buffer_taps: row-major pixel stream to K-high vertical tap columns.
// Ports: clk, rstn (async, active-low), start (frame enable),
//   din/din_valid (pixel in, no backpressure), taps (K*DW column,
//   oldest row at MSB), taps_valid, out_row/out_col (coords of taps),
//   frame_done (1-cycle pulse after the last valid column).
// Option: define LB_BORDER_MASK_EN to flag only columns with out_col >= K-1.
module line_buffer_taps #(
   parameter int K  = 5,
   parameter int Ni = 28,
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic [DW-1:0]   din,
   input  logic            din_valid,
   output logic [K*DW-1:0] taps,
   output logic            taps_valid,
   output logic [9:0]      out_row,
   output logic [9:0]      out_col,
   output logic            frame_done
);

   localparam int CW = (Ni > 1) ? $clog2(Ni) : 1;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      RUN,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic [9:0]        row_q, row_d;
   logic [9:0]        col_q, col_d;
   logic [K*DW-1:0]   taps_q, taps_d;
   logic              tv_q, tv_d;
   logic [9:0]        orow_q, orow_d;
   logic [9:0]        ocol_q, ocol_d;
   logic              fd_q, fd_d;

   // lb[0] is the previous row, lb[K-2] the oldest
   logic [DW-1:0]     lb [K-1][Ni];

   logic [CW-1:0]     col_idx;
   logic [K*DW-1:0]   column;
   logic              accept;
   logic              last_col;
   logic              mask_ok;

   assign col_idx  = col_q[CW-1:0];
   assign last_col = (col_q == 10'(Ni - 1));
   assign accept   = start && din_valid &&
                     ((state_q == FILL) || (state_q == RUN));

`ifdef LB_BORDER_MASK_EN
   assign mask_ok = (col_q >= 10'(K - 1));
`else
   assign mask_ok = 1'b1;
`endif

   // Column is assembled from the line arrays before they shift
   always_comb begin
      column = '0;
      column[DW-1:0] = din;
      for (int j = 0; j < K - 1; j++) begin
         column[(j+1)*DW +: DW] = lb[j][col_idx];
      end
   end

   // Line storage is not reset; its contents only reach a valid
   // column after K-1 fresh rows of the current frame are written.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb[0][col_idx] <= din;
         for (int j = 1; j < K - 1; j++) begin
            lb[j][col_idx] <= lb[j-1][col_idx];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      taps_d  = taps_q;
      tv_d    = 1'b0;
      orow_d  = orow_q;
      ocol_d  = ocol_q;
      fd_d    = 1'b0;
      if (!start) begin
         state_d = IDLE;
         row_d   = '0;
         col_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               row_d   = '0;
               col_d   = '0;
               state_d = FILL;
            end
            FILL, RUN: begin
               if (din_valid) begin
                  taps_d = column;
                  orow_d = row_q;
                  ocol_d = col_q;
                  tv_d   = (state_q == RUN) && mask_ok;
                  if (last_col) begin
                     col_d = '0;
                     row_d = row_q + 10'd1;
                  end else begin
                     col_d = col_q + 10'd1;
                  end
                  if ((state_q == FILL) && last_col &&
                      (row_q == 10'(K - 2))) begin
                     state_d = RUN;
                  end
                  if ((state_q == RUN) && last_col &&
                      (row_q == 10'(Ni - 1))) begin
                     state_d = DONE;
                     row_d   = '0;
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
               fd_d    = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         taps_q  <= '0;
         tv_q    <= 1'b0;
         orow_q  <= '0;
         ocol_q  <= '0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         taps_q  <= taps_d;
         tv_q    <= tv_d;
         orow_q  <= orow_d;
         ocol_q  <= ocol_d;
         fd_q    <= fd_d;
      end
   end

   assign taps       = taps_q;
   assign taps_valid = tv_q;
   assign out_row    = orow_q;
   assign out_col    = ocol_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_line_buffer_taps.sv
// tb_line_buffer_taps: directed frames with a queue scoreboard.
// A negedge monitor pops one expected column per taps_valid cycle.
module tb_line_buffer_taps;

   localparam int K  = 5;
   localparam int NI = 28;
   localparam int DW = 8;

`ifdef LB_BORDER_MASK_EN
   localparam bit MASK = 1'b1;
   localparam int EXP_VALID = 576;
`else
   localparam bit MASK = 1'b0;
   localparam int EXP_VALID = 672;
`endif

   logic            clk;
   logic            rstn;
   logic            start;
   logic [DW-1:0]   din;
   logic            din_valid;
   logic [K*DW-1:0] taps;
   logic            taps_valid;
   logic [9:0]      out_row;
   logic [9:0]      out_col;
   logic            frame_done;

   line_buffer_taps #(.K(K), .Ni(NI), .DW(DW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .din       (din),
      .din_valid (din_valid),
      .taps      (taps),
      .taps_valid(taps_valid),
      .out_row   (out_row),
      .out_col   (out_col),
      .frame_done(frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int pass_cnt = 0;
   int total_cnt = 0;
   int valid_seen = 0;
   int fd_seen = 0;
   int frames_done = 0;

   logic [DW-1:0]       img [NI][NI];
   logic [K*DW+19:0]    q [$];
   logic [K*DW-1:0]     last_taps;
   bit                  have_last;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [K*DW-1:0] colv(input int r, input int c);
      logic [K*DW-1:0] v;
      for (int j = 0; j < K; j++) v[j*DW +: DW] = img[r-j][c];
      return v;
   endfunction

   // monitor
   initial begin
      logic [K*DW+19:0] e;
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (frame_done) fd_seen++;
            if (taps_valid) begin
               valid_seen++;
               if (q.size() == 0) begin
                  total_cnt++;
                  $display("FAIL unexpected_valid: got row %0d col %0d expected none",
                           out_row, out_col);
               end else begin
                  e = q.pop_front();
                  chk("column", {taps, out_row, out_col}, 64'(e));
               end
            end
         end
      end
   end

   task automatic drive(input int r, input int c);
      din = img[r][c];
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      if (r >= K - 1) begin
         have_last = 1'b1;
         last_taps = colv(r, c);
         if (!MASK || c >= K - 1)
            q.push_back({colv(r, c), 10'(r), 10'(c)});
      end
   endtask

   task automatic gap_cycle();
      din_valid = 1'b0;
      din = 8'($urandom);
      @(posedge clk);
      #1;
      chk("gap_valid", 64'(taps_valid), 64'd0);
      if (have_last) chk("gap_hold", 64'(taps), 64'(last_taps));
   endtask

   // kind 0 ramp, 1 random; ab 1 drops start, 2 pulses rstn at (ar,ac)
   task automatic frame(input int kind, input int gap, input bit b2b,
                        input int ab, input int ar, input int ac);
      int v0;
      for (int r = 0; r < NI; r++)
         for (int c = 0; c < NI; c++)
            img[r][c] = (kind == 0) ? 8'((r * NI + c) % 256)
                                    : 8'($urandom);
      have_last = 1'b0;
      if (!b2b) begin
         start = 1'b1;
         din_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      v0 = valid_seen;
      for (int r = 0; r < NI; r++) begin
         for (int c = 0; c < NI; c++) begin
            if (ab == 1 && r == ar && c == ac) begin
               start = 1'b0;
               din_valid = 1'b1;
               din = 8'hA5;
               @(posedge clk);
               #1;
               chk("drop_valid", 64'(taps_valid), 64'd0);
               chk("drop_fd", 64'(frame_done), 64'd0);
               repeat (2) begin
                  @(posedge clk);
                  #1;
                  chk("drop_quiet", {taps_valid, frame_done}, 64'd0);
               end
               chk("drop_q_empty", 64'(q.size()), 64'd0);
               din_valid = 1'b0;
               return;
            end
            if (ab == 2 && r == ar && c == ac) begin
               din_valid = 1'b0;
               #2;
               rstn = 1'b0;
               #1;
               chk("rst_taps", 64'(taps), 64'd0);
               chk("rst_tv", 64'(taps_valid), 64'd0);
               chk("rst_rc", {out_row, out_col}, 64'd0);
               chk("rst_fd", 64'(frame_done), 64'd0);
               q.delete();
               start = 1'b0;
               @(posedge clk);
               #1;
               rstn = 1'b1;
               @(posedge clk);
               #1;
               return;
            end
            for (int g = 0; g < 3; g++)
               if (gap > 0 && $urandom_range(99) < gap) gap_cycle();
            drive(r, c);
            if (kind == 0 && r == K - 1 && c == 0) begin
               chk("first_taps", 64'(taps), 64'h00_1C_38_54_70);
               chk("first_tv", 64'(taps_valid), 64'(!MASK));
               chk("first_rc", {out_row, out_col}, {10'd4, 10'd0});
            end
         end
      end
      chk("last_tv", 64'(taps_valid), 64'd1);
      chk("fd_t1", 64'(frame_done), 64'd0);
      din_valid = 1'b1;
      din = 8'h5A;
      @(posedge clk);
      #1;
      chk("fd_t2", {frame_done, taps_valid}, 64'b10);
      @(posedge clk);
      #1;
      chk("fd_t3", {frame_done, taps_valid}, 64'b00);
      din_valid = 1'b0;
      chk("valid_count", 64'(valid_seen - v0), 64'(EXP_VALID));
      frames_done++;
   endtask

   initial begin
      rstn = 1'b0;
      start = 1'b0;
      din = '0;
      din_valid = 1'b0;
      have_last = 1'b0;
      last_taps = '0;
      #12;
      chk("reset_taps", 64'(taps), 64'd0);
      chk("reset_tv", 64'(taps_valid), 64'd0);
      chk("reset_row", 64'(out_row), 64'd0);
      chk("reset_col", 64'(out_col), 64'd0);
      chk("reset_fd", 64'(frame_done), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      frame(0, 0, 1'b0, 0, 0, 0);
      frame(1, 0, 1'b0, 0, 0, 0);
      frame(1, 50, 1'b0, 0, 0, 0);
      frame(0, 0, 1'b0, 1, 10, 5);
      frame(0, 0, 1'b0, 0, 0, 0);
      frame(0, 0, 1'b0, 2, 15, 7);
      frame(0, 0, 1'b0, 0, 0, 0);
      frame(1, 0, 1'b0, 0, 0, 0);
      frame(1, 0, 1'b1, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("q_drained", 64'(q.size()), 64'd0);
      chk("fd_pulses", 64'(fd_seen), 64'(frames_done));
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
